edge_threshold: RTL and testbench

Downstream stage of the Sobel gradient filter. It consumes the 11-bit |Gx|+|Gy| stream and its valid strobe, and produces a binary edge map (0/255) plus an 8-bit saturated magnitude. Each output pixel carries row/column coordinates, end-of-line and end-of-frame pulses, and a per-frame edge count. Its output feeds the frame writer / display path.

---
 rtl/edge_pkg.sv | 27 ++
 rtl/pix_coord_counter.sv | 34 +++
 rtl/edge_threshold.sv | 130 +++++++++++++
 tb/tb_edge_threshold.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants and types for the Sobel edge thresholding path.
package edge_pkg;

  localparam int GRAD_W  = 11;
  localparam int PIX_W   = 8;
  localparam int COORD_W = 6;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef logic [COORD_W-1:0] coord_t;

  // Per-sample side information that travels with the gradient through S1.
  typedef struct packed {
    logic   hit;
    logic   first;
    logic   last_col;
    logic   last_px;
    coord_t col;
    coord_t row;
  } pix_tag_t;

endpackage

// File: rtl/pix_coord_counter.sv
// Column/row position of the next accepted sample, wrapping at the frame end.
module pix_coord_counter
  import edge_pkg::*;
#(
  parameter int COLS = 2,
  parameter int ROWS = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  output coord_t col,
  output coord_t row,
  output logic   last_col,
  output logic   last_px
);

  assign last_col = (col == COORD_W'(COLS - 1));
  assign last_px  = last_col && (row == COORD_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_col) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_threshold.sv
// Gradient-to-edge-map stage: threshold compare, 8-bit magnitude, coordinates,
// line/frame pulses and a per-frame edge count. Two-stage pipeline, no stalls.
module edge_threshold #(
  parameter int GRAD_W   = edge_pkg::GRAD_W,
  parameter int OUT_COLS = 2,
  parameter int OUT_ROWS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [GRAD_W-1:0]            gradient,
  input  logic                         gradient_valid,
  input  logic [GRAD_W-1:0]            threshold,
  output logic [edge_pkg::PIX_W-1:0]   edge_pixel,
  output logic [edge_pkg::PIX_W-1:0]   mag_pixel,
  output logic                         edge_valid,
  output logic [edge_pkg::COORD_W-1:0] out_col,
  output logic [edge_pkg::COORD_W-1:0] out_row,
  output logic                         line_done,
  output logic                         frame_done,
  output logic [CNT_W-1:0]             edge_count
);
  import edge_pkg::*;

  localparam int STAGES = 2;
  localparam logic [GRAD_W-1:0] PIX_MAX = GRAD_W'(255);

  logic [1:0]        state, state_nx;
  logic [GRAD_W-1:0] thr_shadow, thr_eff;
  logic              frame_start;
  coord_t            cur_col, cur_row;
  logic              cur_last_col, cur_last_px;

  logic [STAGES:1]   vld_pipe;
  logic [GRAD_W-1:0] s1_grad;
  pix_tag_t          s1_tag;
  logic              s2_last;
  logic [CNT_W-1:0]  run_cnt;

  pix_coord_counter #(
    .COLS(OUT_COLS),
    .ROWS(OUT_ROWS)
  ) u_coord (
    .clk      (clk),
    .rst      (rst),
    .adv      (gradient_valid),
    .col      (cur_col),
    .row      (cur_row),
    .last_col (cur_last_col),
    .last_px  (cur_last_px)
  );

  // Any sample outside ACTIVE opens a new frame, including one landing in DONE;
  // its own compare must already see the freshly sampled threshold.
  assign frame_start = gradient_valid && (state != ST_ACTIVE);
  assign thr_eff     = frame_start ? threshold : thr_shadow;

  always_comb begin
    state_nx = state;
    case (state)
      ST_ACTIVE: if (gradient_valid && cur_last_px) state_nx = ST_DONE;
      ST_IDLE, ST_DONE: begin
        if (gradient_valid) state_nx = cur_last_px ? ST_DONE : ST_ACTIVE;
        else                state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // S1: capture sample, compare result and position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      thr_shadow  <= '0;
      vld_pipe[1] <= 1'b0;
      s1_grad     <= '0;
      s1_tag      <= '0;
    end else begin
      state       <= state_nx;
      vld_pipe[1] <= gradient_valid;
      if (frame_start) thr_shadow <= threshold;
      if (gradient_valid) begin
        s1_grad         <= gradient;
        s1_tag.hit      <= (gradient >= thr_eff);
        s1_tag.first    <= frame_start;
        s1_tag.last_col <= cur_last_col;
        s1_tag.last_px  <= cur_last_px;
        s1_tag.col      <= cur_col;
        s1_tag.row      <= cur_row;
      end
    end
  end

  // S2: output registers, running count, frame wrap-up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      edge_pixel  <= '0;
      mag_pixel   <= '0;
      out_col     <= '0;
      out_row     <= '0;
      line_done   <= 1'b0;
      s2_last     <= 1'b0;
      frame_done  <= 1'b0;
      run_cnt     <= '0;
      edge_count  <= '0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      line_done   <= vld_pipe[1] && s1_tag.last_col;
      s2_last     <= vld_pipe[1] && s1_tag.last_px;
      frame_done  <= s2_last;
      if (vld_pipe[1]) begin
        edge_pixel <= s1_tag.hit ? EDGE_ON : EDGE_OFF;
        mag_pixel  <= (s1_grad > PIX_MAX) ? EDGE_ON : s1_grad[PIX_W-1:0];
        out_col    <= s1_tag.col;
        out_row    <= s1_tag.row;
        // The first pixel restarts the count, so a new frame can overlap the
        // previous frame's wrap-up without disturbing its result.
        if (s1_tag.first)
          run_cnt <= s1_tag.hit ? CNT_W'(1) : '0;
        else if (s1_tag.hit && (run_cnt != '1))
          run_cnt <= run_cnt + 1'b1;
      end
      if (s2_last) edge_count <= run_cnt;
    end
  end

  assign edge_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_edge_threshold.sv
// Directed bench for edge_threshold with 2x2 frames and hand-computed results.
module tb_edge_threshold;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] gradient;
  logic        gradient_valid;
  logic [10:0] threshold;
  logic [7:0]  edge_pixel, mag_pixel;
  logic        edge_valid;
  logic [5:0]  out_col, out_row;
  logic        line_done, frame_done;
  logic [15:0] edge_count;

  edge_threshold #(.GRAD_W(11), .OUT_COLS(2), .OUT_ROWS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .gradient(gradient), .gradient_valid(gradient_valid),
    .threshold(threshold), .edge_pixel(edge_pixel), .mag_pixel(mag_pixel),
    .edge_valid(edge_valid), .out_col(out_col), .out_row(out_row),
    .line_done(line_done), .frame_done(frame_done), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] e, m;
    logic [5:0] col, row;
    logic       ld;
  } rec_t;

  int          cyc = 0;
  int          passed = 0, total = 0;
  int          in_q[$];
  rec_t        out_q[$];
  int          fd_q[$];
  logic [15:0] fc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (edge_valid) out_q.push_back('{cyc, edge_pixel, mag_pixel, out_col, out_row, line_done});
    if (frame_done) begin
      fd_q.push_back(cyc);
      fc_q.push_back(edge_count);
    end
  end

  task automatic send(input logic [10:0] g);
    gradient = g;
    gradient_valid = 1'b1;
    in_q.push_back(cyc);
    @(negedge clk);
    gradient_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    in_q.delete(); out_q.delete(); fd_q.delete(); fc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; gradient = '0; gradient_valid = 1'b0; threshold = '0;
    idle(3);
    total++;
    if ({edge_pixel, mag_pixel, edge_valid, out_col, out_row, line_done, frame_done, edge_count} !== '0)
      $display("FAIL reset: got e=%h m=%h v=%b col=%0d row=%0d ld=%b fd=%b cnt=%0d, want all 0",
               edge_pixel, mag_pixel, edge_valid, out_col, out_row, line_done, frame_done, edge_count);
    else passed++;
    rst = 1'b0;
    idle(2);
    total++;
    if ({edge_valid, line_done, frame_done} !== 3'b000)
      $display("FAIL reset_idle: got v=%b ld=%b fd=%b, want 000", edge_valid, line_done, frame_done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ee [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] em [4] = '{8'd50, 8'd100, 8'd255, 8'd0};
    logic [5:0] ec [4] = '{6'd0, 6'd1, 6'd0, 6'd1};
    logic [5:0] er [4] = '{6'd0, 6'd0, 6'd1, 6'd1};
    clear_q();
    threshold = 11'd100;
    send(11'd50); send(11'd100); send(11'd2040); send(11'd0);
    idle(6);
    total++;
    if (out_q.size() != 4) $display("FAIL b2b_count: got %0d outputs, want 4", out_q.size());
    else passed++;
    for (int i = 0; i < 4; i++) if (i < out_q.size()) begin
      total++;
      if ({out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld} !==
          {in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]})
        $display("FAIL b2b_px%0d: got c=%0d e=%h m=%0d (%0d,%0d) ld=%b, want c=%0d e=%h m=%0d (%0d,%0d) ld=%b",
                 i, out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld,
                 in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]);
      else passed++;
    end
    total++;
    if (fd_q.size() != 1 || fd_q[0] != in_q[3] + 3 || fc_q[0] !== 16'd2)
      $display("FAIL b2b_frame: got %0d pulses first at c=%0d cnt=%0d, want 1 at c=%0d cnt=2",
               fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF, in_q[3] + 3);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [7:0] ee [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] em [4] = '{8'd50, 8'd100, 8'd255, 8'd0};
    logic [5:0] ec [4] = '{6'd0, 6'd1, 6'd0, 6'd1};
    logic [5:0] er [4] = '{6'd0, 6'd0, 6'd1, 6'd1};
    clear_q();
    threshold = 11'd100;
    send(11'd50); idle(3);
    send(11'd100); idle(3);
    send(11'd2040);
    idle(2);
    total++;
    if ({edge_valid, edge_pixel, mag_pixel} !== {1'b0, 8'hFF, 8'd255})
      $display("FAIL gaps_hold: got v=%b e=%h m=%0d, want v=0 e=ff m=255", edge_valid, edge_pixel, mag_pixel);
    else passed++;
    idle(1);
    send(11'd0);
    idle(6);
    total++;
    if (out_q.size() != 4) $display("FAIL gaps_count: got %0d outputs, want 4", out_q.size());
    else passed++;
    for (int i = 0; i < 4; i++) if (i < out_q.size()) begin
      total++;
      if ({out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld} !==
          {in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]})
        $display("FAIL gaps_px%0d: got c=%0d e=%h m=%0d (%0d,%0d) ld=%b, want c=%0d e=%h m=%0d (%0d,%0d) ld=%b",
                 i, out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld,
                 in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]);
      else passed++;
    end
    total++;
    if (fd_q.size() != 1 || fd_q[0] != in_q[3] + 3 || fc_q[0] !== 16'd2)
      $display("FAIL gaps_frame: got %0d pulses, cnt=%0d, want 1 at c=%0d cnt=2",
               fd_q.size(), (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF, in_q[3] + 3);
    else passed++;
  endtask

  task automatic test_threshold_change();
    logic [7:0] ee [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    clear_q();
    threshold = 11'd100;
    send(11'd50);
    threshold = 11'd10;
    send(11'd100); send(11'd2040); send(11'd0);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= out_q.size()) $display("FAIL thr_px%0d: missing output, want e=%h", i, ee[i]);
      else if (out_q[i].e !== ee[i]) $display("FAIL thr_px%0d: got e=%h, want e=%h", i, out_q[i].e, ee[i]);
      else passed++;
    end
    total++;
    if (fc_q.size() != 1 || fc_q[0] !== 16'd2)
      $display("FAIL thr_frame1: got %0d pulses cnt=%0d, want 1 pulse cnt=2",
               fc_q.size(), (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF);
    else passed++;
    clear_q();
    repeat (4) send(11'd50);
    idle(6);
    total++;
    if (fc_q.size() != 1 || fc_q[0] !== 16'd4)
      $display("FAIL thr_frame2: got %0d pulses cnt=%0d, want 1 pulse cnt=4",
               fc_q.size(), (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] ee [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [5:0] ec [4] = '{6'd0, 6'd1, 6'd0, 6'd1};
    logic [5:0] er [4] = '{6'd0, 6'd0, 6'd1, 6'd1};
    threshold = 11'd100;
    send(11'd200); send(11'd200); send(11'd200);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({edge_pixel, mag_pixel, edge_valid, out_col, out_row, line_done, frame_done, edge_count} !== '0)
      $display("FAIL midrst_zero: got e=%h m=%0d v=%b col=%0d row=%0d ld=%b fd=%b cnt=%0d, want all 0",
               edge_pixel, mag_pixel, edge_valid, out_col, out_row, line_done, frame_done, edge_count);
    else passed++;
    rst = 1'b0;
    clear_q();
    idle(6);
    total++;
    if (fd_q.size() != 0 || out_q.size() != 0)
      $display("FAIL midrst_discard: got %0d frame pulses %0d outputs, want 0 and 0", fd_q.size(), out_q.size());
    else passed++;
    clear_q();
    send(11'd200); send(11'd0); send(11'd100); send(11'd99);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= out_q.size()) $display("FAIL midrst_px%0d: missing output", i);
      else if ({out_q[i].c, out_q[i].e, out_q[i].col, out_q[i].row} !== {in_q[i] + 2, ee[i], ec[i], er[i]})
        $display("FAIL midrst_px%0d: got c=%0d e=%h (%0d,%0d), want c=%0d e=%h (%0d,%0d)",
                 i, out_q[i].c, out_q[i].e, out_q[i].col, out_q[i].row, in_q[i] + 2, ee[i], ec[i], er[i]);
      else passed++;
    end
    total++;
    if (fc_q.size() != 1 || fc_q[0] !== 16'd2)
      $display("FAIL midrst_frame: got %0d pulses cnt=%0d, want 1 pulse cnt=2",
               fc_q.size(), (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF);
    else passed++;
  endtask

  task automatic test_done_overlap();
    logic [7:0] ee [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] em [8] = '{8'd150, 8'd150, 8'd150, 8'd150, 8'd5, 8'd20, 8'd5, 8'd20};
    logic [5:0] ec [8] = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd1};
    logic [5:0] er [8] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd0, 6'd0, 6'd1, 6'd1};
    clear_q();
    threshold = 11'd100;
    repeat (4) send(11'd150);
    threshold = 11'd10;
    send(11'd5); send(11'd20); send(11'd5); send(11'd20);
    idle(6);
    total++;
    if (out_q.size() != 8) $display("FAIL overlap_count: got %0d outputs, want 8", out_q.size());
    else passed++;
    for (int i = 0; i < 8; i++) if (i < out_q.size()) begin
      total++;
      if ({out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld} !==
          {in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]})
        $display("FAIL overlap_px%0d: got c=%0d e=%h m=%0d (%0d,%0d) ld=%b, want c=%0d e=%h m=%0d (%0d,%0d) ld=%b",
                 i, out_q[i].c, out_q[i].e, out_q[i].m, out_q[i].col, out_q[i].row, out_q[i].ld,
                 in_q[i] + 2, ee[i], em[i], ec[i], er[i], ec[i][0]);
      else passed++;
    end
    total++;
    if (fd_q.size() != 2 || fd_q[0] != in_q[3] + 3 || fd_q[1] != in_q[7] + 3 ||
        fc_q[0] !== 16'd4 || fc_q[1] !== 16'd2)
      $display("FAIL overlap_frames: got %0d pulses cnts=%0d,%0d, want 2 pulses at c=%0d,%0d cnts=4,2",
               fd_q.size(), (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF, (fc_q.size() > 1) ? fc_q[1] : 16'hFFFF,
               in_q[3] + 3, in_q[7] + 3);
    else passed++;
  endtask

  task automatic test_threshold_limits();
    clear_q();
    threshold = 11'd0;
    send(11'd0); send(11'd0); send(11'd5); send(11'd2040);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= out_q.size() || out_q[i].e !== 8'hFF)
        $display("FAIL thr0_px%0d: got e=%h, want ff", i, (i < out_q.size()) ? out_q[i].e : 8'hxx);
      else passed++;
    end
    total++;
    if (fc_q.size() != 1 || fc_q[0] !== 16'd4)
      $display("FAIL thr0_frame: got cnt=%0d, want 4", (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF);
    else passed++;
    clear_q();
    threshold = 11'd2041;
    send(11'd2040); send(11'd2040); send(11'd0); send(11'd1000);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= out_q.size() || out_q[i].e !== 8'h00)
        $display("FAIL thrmax_px%0d: got e=%h, want 00", i, (i < out_q.size()) ? out_q[i].e : 8'hxx);
      else passed++;
    end
    total++;
    if (fc_q.size() != 1 || fc_q[0] !== 16'd0)
      $display("FAIL thrmax_frame: got cnt=%0d, want 0", (fc_q.size() > 0) ? fc_q[0] : 16'hFFFF);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; gradient = '0; gradient_valid = 1'b0; threshold = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_gaps();
    test_threshold_change();
    test_mid_reset();
    test_done_overlap();
    test_threshold_limits();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
